// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache refill paths, the arbiter and the main-memory port.
// The arbiter uses the slave modport; the caches and memory model drive through master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid;

    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_rw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic              dc_wdata_valid;
    logic              dc_wdata_ready;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_resp_valid;

    logic [DATA_W-1:0] resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_wdata_valid;
    logic              mem_wdata_ready;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_wdata_valid, dc_wdata,
        input  mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data,
        output ic_req_ready, ic_resp_valid,
        output dc_req_ready, dc_wdata_ready, dc_resp_valid,
        output resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_wdata_valid, dc_wdata,
        output mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data,
        input  ic_req_ready, ic_resp_valid,
        input  dc_req_ready, dc_wdata_ready, dc_resp_valid,
        input  resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between icache refills and dcache refills/writebacks.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise dcache has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus,
    output logic           busy
);

    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    logic [1:0]        state;
    logic              owner;
    logic [CNT_W-1:0]  beat_cnt;
    logic              grant_dc;
    logic              beat_xfer;
    logic              owner_is_write;
    logic [ADDR_W-1:0] owner_addr;
    logic [DATA_W-1:0] wr_beat;
    logic [DATA_W-1:0] rd_beat;

`ifdef MEM_ARB_RR_EN
    logic last_grant;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        grant_dc = bus.dc_req_valid && (!bus.ic_req_valid || last_grant == OWN_IC);
    end
`else
    always_comb begin
        grant_dc = bus.dc_req_valid;
    end
`endif

    // Requesters hold address/rw until accepted, so no local copy is needed.
    assign owner_addr     = (owner == OWN_DC) ? bus.dc_req_addr : bus.ic_req_addr;
    assign owner_is_write = (owner == OWN_DC) && bus.dc_req_rw;

    assign wr_beat       = bus.dc_wdata;
    assign bus.mem_wdata = wr_beat;
    assign rd_beat       = bus.mem_resp_data;
    assign bus.resp_data = rd_beat;

    assign busy = (state != ST_IDLE);

    always_comb begin
        bus.mem_req_valid   = 1'b0;
        bus.mem_req_rw      = 1'b0;
        bus.mem_req_addr    = '0;
        bus.ic_req_ready    = 1'b0;
        bus.dc_req_ready    = 1'b0;
        bus.mem_wdata_valid = 1'b0;
        bus.dc_wdata_ready  = 1'b0;
        bus.ic_resp_valid   = 1'b0;
        bus.dc_resp_valid   = 1'b0;
        beat_xfer           = 1'b0;
        case (state)
            ST_ADDR: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_rw    = owner_is_write;
                bus.mem_req_addr  = owner_addr;
                bus.ic_req_ready  = bus.mem_req_ready && (owner == OWN_IC);
                bus.dc_req_ready  = bus.mem_req_ready && (owner == OWN_DC);
            end
            ST_WDATA: begin
                bus.mem_wdata_valid = bus.dc_wdata_valid;
                bus.dc_wdata_ready  = bus.mem_wdata_ready;
                beat_xfer           = bus.dc_wdata_valid && bus.mem_wdata_ready;
            end
            ST_RDATA: begin
                bus.ic_resp_valid = bus.mem_resp_valid && (owner == OWN_IC);
                bus.dc_resp_valid = bus.mem_resp_valid && (owner == OWN_DC);
                beat_xfer         = bus.mem_resp_valid;
            end
            default: ;
        endcase
    end

    // Returning to IDLE after the last beat gives one bubble before the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner    <= OWN_IC;
            beat_cnt <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant <= OWN_IC;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.ic_req_valid || bus.dc_req_valid) begin
                        owner <= grant_dc ? OWN_DC : OWN_IC;
                        state <= ST_ADDR;
`ifdef MEM_ARB_RR_EN
                        last_grant <= grant_dc ? OWN_DC : OWN_IC;
`endif
                    end
                end
                ST_ADDR: begin
                    if (bus.mem_req_ready) begin
                        state <= owner_is_write ? ST_WDATA : ST_RDATA;
                    end
                end
                default: begin
                    if (beat_xfer) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model compared every cycle,
// plus directed literal checks; honours MEM_ARB_RR_EN when the build defines it.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BEATS  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy, busy1;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) u_dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;
    bit compare_en = 1'b0;

    // Requesters: a request stays valid while issued > accepted.
    int ic_issue = 0, ic_acc = 0, dc_issue = 0, dc_acc = 0;
    logic req_rdy = 1'b1, stray = 1'b0, wr_toggle = 1'b0, wtog = 1'b1;
    logic [DATA_W-1:0] rd_base = 32'hA0;
    int rd_left = 0;
    logic rv_q = 1'b0;
    logic [DATA_W-1:0] rd_q = '0;
    logic wr_active = 1'b0;
    int wbeat = 0;
    int vlen = 0;

    assign bus.ic_req_valid    = (ic_issue != ic_acc);
    assign bus.dc_req_valid    = (dc_issue != dc_acc);
    assign bus.mem_req_ready   = req_rdy;
    assign bus.mem_resp_valid  = rv_q | stray;
    assign bus.mem_resp_data   = stray ? 32'hEE : rd_q;
    assign bus.dc_wdata_valid  = wr_active;
    assign bus.dc_wdata        = 32'hD0 + 32'(wbeat);
    assign bus.mem_wdata_ready = wtog;

    // Behavioural model: one outstanding transaction described by who owns it,
    // whether its address was taken and how many beats have moved.
    bit m_granted = 1'b0, m_accepted = 1'b0, m_owner_dc = 1'b0, m_rw = 1'b0, m_last_dc = 1'b0;
    int m_done = 0;
    bit m_grants[$];

    bit     acc_log[$];
    logic [ADDR_W-1:0] addr_log[$];
    int     len_log[$];
    logic [DATA_W-1:0] ic_data_q[$];
    logic [DATA_W-1:0] dc_data_q[$];
    logic [DATA_W-1:0] wr_log[$];

    function automatic bit pick_dc(bit ic, bit dc, bit last_dc);
`ifdef MEM_ARB_RR_EN
        if (ic && dc) return !last_dc;
`endif
        return dc;
    endfunction

    function automatic int next_left();
        if (bus.mem_req_valid && req_rdy && !bus.mem_req_rw) return BEATS;
        return rd_left - (rv_q ? 1 : 0);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_granted  <= 1'b0;
            m_accepted <= 1'b0;
            m_done     <= 0;
            m_last_dc  <= 1'b0;
        end else if (!m_granted) begin
            if (bus.ic_req_valid || bus.dc_req_valid) begin
                m_granted  <= 1'b1;
                m_accepted <= 1'b0;
                m_done     <= 0;
                m_owner_dc <= pick_dc(bus.ic_req_valid, bus.dc_req_valid, m_last_dc);
                m_last_dc  <= pick_dc(bus.ic_req_valid, bus.dc_req_valid, m_last_dc);
                m_grants.push_back(pick_dc(bus.ic_req_valid, bus.dc_req_valid, m_last_dc));
            end
        end else if (!m_accepted) begin
            if (req_rdy) begin
                m_accepted <= 1'b1;
                m_rw       <= m_owner_dc && bus.dc_req_rw;
            end
        end else if (m_rw ? (wr_active && wtog) : (rv_q | stray)) begin
            if (m_done == BEATS - 1) begin
                m_granted  <= 1'b0;
                m_accepted <= 1'b0;
                m_done     <= 0;
            end else begin
                m_done <= m_done + 1;
            end
        end
    end

    // Memory model: streams BEATS read beats right after accepting a read address.
    always @(posedge clk) begin
        if (reset) begin
            rd_left <= 0;
            rv_q    <= 1'b0;
        end else begin
            rd_left <= next_left();
            rv_q    <= (next_left() > 0);
            rd_q    <= rd_base + 32'(BEATS - next_left());
        end
        wtog <= wr_toggle ? !wtog : 1'b1;
    end

    // Requester side: count acceptances and feed dcache write beats.
    always @(posedge clk) begin
        if (bus.ic_req_ready) ic_acc <= ic_acc + 1;
        if (bus.dc_req_ready) dc_acc <= dc_acc + 1;
        if (reset) begin
            wr_active <= 1'b0;
            wbeat     <= 0;
        end else if (bus.dc_req_ready && bus.dc_req_rw) begin
            wr_active <= 1'b1;
            wbeat     <= 0;
        end else if (wr_active && bus.dc_wdata_ready) begin
            wbeat <= wbeat + 1;
            if (wbeat == BEATS - 1) wr_active <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareCycle();
        bit addr_ph, rd_ph, wr_ph;
        addr_ph = m_granted && !m_accepted;
        wr_ph   = m_granted && m_accepted && m_rw;
        rd_ph   = m_granted && m_accepted && !m_rw;
        checkOutput("busy", busy, m_granted);
        checkOutput("mem_req_valid", bus.mem_req_valid, addr_ph);
        checkOutput("mem_req_addr", bus.mem_req_addr,
                    addr_ph ? (m_owner_dc ? bus.dc_req_addr : bus.ic_req_addr) : '0);
        checkOutput("mem_req_rw", bus.mem_req_rw, addr_ph && m_owner_dc && bus.dc_req_rw);
        checkOutput("ic_req_ready", bus.ic_req_ready, addr_ph && !m_owner_dc && req_rdy);
        checkOutput("dc_req_ready", bus.dc_req_ready, addr_ph && m_owner_dc && req_rdy);
        checkOutput("mem_wdata_valid", bus.mem_wdata_valid, wr_ph && wr_active);
        checkOutput("dc_wdata_ready", bus.dc_wdata_ready, wr_ph && wtog);
        checkOutput("mem_wdata", bus.mem_wdata, 32'hD0 + 32'(wbeat));
        checkOutput("ic_resp_valid", bus.ic_resp_valid, rd_ph && !m_owner_dc && (rv_q | stray));
        checkOutput("dc_resp_valid", bus.dc_resp_valid, rd_ph && m_owner_dc && (rv_q | stray));
        checkOutput("resp_data", bus.resp_data, stray ? 32'hEE : rd_q);
        if (bus.ic_resp_valid) ic_data_q.push_back(bus.resp_data);
        if (bus.dc_resp_valid) dc_data_q.push_back(bus.resp_data);
        if (bus.mem_wdata_valid && wtog) wr_log.push_back(bus.mem_wdata);
        if (bus.mem_req_valid) begin
            if (bus.ic_req_ready || bus.dc_req_ready) begin
                acc_log.push_back(bus.dc_req_ready);
                addr_log.push_back(bus.mem_req_addr);
                len_log.push_back(vlen + 1);
                vlen <= 0;
            end else begin
                vlen <= vlen + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (compare_en) compareCycle();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        acc_log.delete(); addr_log.delete(); len_log.delete();
        ic_data_q.delete(); dc_data_q.delete(); wr_log.delete(); m_grants.delete();
    endtask

    task automatic applyStimulus(input bit use_ic, input bit use_dc, input bit rw,
                                 input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da);
        bus.ic_req_addr = ia;
        bus.dc_req_addr = da;
        bus.dc_req_rw   = rw;
        if (use_ic) ic_issue++;
        if (use_dc) dc_issue++;
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (n < 300 && (busy || ic_issue != ic_acc || dc_issue != dc_acc)) begin
            step();
            n++;
        end
        checkOutput(name, {busy, 1'b0, ic_issue != ic_acc, dc_issue != dc_acc}, '0);
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.ic_req_addr = '0; bus.dc_req_addr = '0; bus.dc_req_rw = 1'b0;
        bus1.ic_req_valid = 1'b0; bus1.ic_req_addr = '0; bus1.dc_req_valid = 1'b0;
        bus1.dc_req_rw = 1'b0; bus1.dc_req_addr = '0; bus1.dc_wdata_valid = 1'b0;
        bus1.dc_wdata = '0; bus1.mem_req_ready = 1'b0; bus1.mem_wdata_ready = 1'b0;
        bus1.mem_resp_valid = 1'b0; bus1.mem_resp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        compare_en = 1'b1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_mem_req_valid", bus.mem_req_valid, 0);
        checkOutput("reset_ic_resp_valid", bus.ic_resp_valid, 0);

        // Lone icache read
        clearLogs();
        applyStimulus(1, 0, 0, 32'h1000, 32'h0);
        waitDone("t1_done");
        checkOutput("t1_beats", ic_data_q.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput("t1_data", ic_data_q[i], 32'hA0 + 32'(i));
        checkOutput("t1_dc_beats", dc_data_q.size(), 0);
        checkOutput("t1_addr", addr_log[0], 32'h1000);
        checkOutput("t1_latency", len_log[0], 1);

        // Simultaneous requests, one each
        clearLogs();
        applyStimulus(1, 1, 0, 32'h1000, 32'h2000);
        waitDone("t2_done");
        checkOutput("t2_first_dc", acc_log[0], 1);
        checkOutput("t2_second_ic", acc_log[1], 0);
        checkOutput("t2_addr0", addr_log[0], 32'h2000);
        checkOutput("t2_addr1", addr_log[1], 32'h1000);
        checkOutput("t2_model_g0", m_grants[0], 1);
        checkOutput("t2_model_g1", m_grants[1], 0);
        checkOutput("t2_beats", ic_data_q.size() + dc_data_q.size(), 8);

        // Both requesters continuously asking for two lines each
        clearLogs();
        ic_issue += 2;
        dc_issue += 2;
        waitDone("t2b_done");
`ifdef MEM_ARB_RR_EN
        checkOutput("t2b_order", {acc_log[0], acc_log[1], acc_log[2], acc_log[3]}, 4'b1010);
        checkOutput("t2b_model", {m_grants[0], m_grants[1], m_grants[2], m_grants[3]}, 4'b1010);
`else
        checkOutput("t2b_order", {acc_log[0], acc_log[1], acc_log[2], acc_log[3]}, 4'b1100);
        checkOutput("t2b_model", {m_grants[0], m_grants[1], m_grants[2], m_grants[3]}, 4'b1100);
`endif

        // dcache writeback with throttled memory
        clearLogs();
        wr_toggle = 1'b1;
        applyStimulus(0, 1, 1, 32'h0, 32'h3000);
        waitDone("t3_done");
        wr_toggle = 1'b0;
        bus.dc_req_rw = 1'b0;
        checkOutput("t3_beats", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput("t3_wdata", wr_log[i], 32'hD0 + 32'(i));
        checkOutput("t3_addr", addr_log[0], 32'h3000);

        // Address phase stalled by memory for five cycles
        clearLogs();
        req_rdy = 1'b0;
        applyStimulus(1, 0, 0, 32'h4000, 32'h0);
        repeat (6) step();
        req_rdy = 1'b1;
        waitDone("t4_done");
        checkOutput("t4_addr_cycles", len_log[0], 6);

        // Reset in the middle of a read burst
        clearLogs();
        applyStimulus(1, 0, 0, 32'h5000, 32'h0);
        for (int n = 0; n < 50 && ic_data_q.size() < 2; n++) step();
        checkOutput("t5_two_beats", ic_data_q.size(), 2);
        reset = 1'b1;
        step();
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_mem_req_valid", bus.mem_req_valid, 0);
        checkOutput("t5_ic_resp_valid", bus.ic_resp_valid, 0);
        reset = 1'b0;
        clearLogs();
        applyStimulus(1, 0, 0, 32'h5100, 32'h0);
        waitDone("t5_done");
        checkOutput("t5_beats", ic_data_q.size(), 4);
        checkOutput("t5_last", ic_data_q[3], 32'hA3);

        // Stray memory beats in IDLE and in the address phase
        clearLogs();
        stray = 1'b1;
        repeat (2) step();
        stray = 1'b0;
        req_rdy = 1'b0;
        applyStimulus(1, 0, 0, 32'h6000, 32'h0);
        step();
        stray = 1'b1;
        repeat (2) step();
        stray = 1'b0;
        req_rdy = 1'b1;
        waitDone("t6_done");
        checkOutput("t6_beats", ic_data_q.size(), 4);
        checkOutput("t6_first", ic_data_q[0], 32'hA0);

        // Single-beat build
        bus1.ic_req_addr = 32'h40;
        bus1.mem_req_ready = 1'b1;
        bus1.ic_req_valid = 1'b1;
        step();
        checkOutput("b1_req_valid", bus1.mem_req_valid, 1);
        checkOutput("b1_addr", bus1.mem_req_addr, 32'h40);
        checkOutput("b1_req_ready", bus1.ic_req_ready, 1);
        step();
        bus1.ic_req_valid = 1'b0;
        bus1.mem_resp_valid = 1'b1;
        bus1.mem_resp_data = 32'h77;
        #1;
        checkOutput("b1_resp_valid", bus1.ic_resp_valid, 1);
        checkOutput("b1_resp_data", bus1.resp_data, 32'h77);
        step();
        bus1.mem_resp_valid = 1'b0;
        #1;
        checkOutput("b1_idle", busy1, 0);
        checkOutput("b1_no_resp", bus1.ic_resp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
